// File: rtl/persp_recip_div_if.sv
// Request/result bundle between the 3D-plane stage and the reciprocal unit.
//   start  : one-cycle request, samples denom
//   denom  : unsigned divisor
//   recip  : registered result, held between completions
//   busy   : an iteration is in progress
//   done   : one-cycle pulse when recip takes a new value
// master = renderer side, slave = divider side.
interface persp_recip_div_if #(
  parameter int unsigned DEN_W = 10,
  parameter int unsigned QUO_W = 11
);
  logic             start;
  logic [DEN_W-1:0] denom;
  logic [QUO_W-1:0] recip;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output denom,
    input  recip,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  denom,
    output recip,
    output busy,
    output done
  );
endinterface

// File: rtl/persp_recip_div.sv
// Sequential reciprocal unit: recip = sat(floor(NUMER / denom)) by restoring
// division, one quotient bit per clk48 edge, NUM_W edges per request
// (the start edge performs the first step).
// Ports:
//   clk48  : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : persp_recip_div_if.slave (start, denom, recip, busy, done)
// Optional build macro PERSP_RECIP_ROUND_EN: round-to-nearest on the
// completion edge (quotient + 1 when 2*rem >= den), same latency.
module persp_recip_div #(
  parameter int unsigned NUMER = 65535,
  parameter int unsigned NUM_W = 16,
  parameter int unsigned DEN_W = 10,
  parameter int unsigned QUO_W = 11
) (
  input  logic                      clk48,
  input  logic                      rst_n,
  persp_recip_div_if.slave          bus
);

  localparam int unsigned CNT_W  = $clog2(NUM_W);
  localparam int unsigned STEP_W = DEN_W + NUM_W;
  localparam logic [NUM_W-1:0] NUMER_V = NUM_W'(NUMER);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DEN_W-1:0]   den_q,   den_d;
  logic [DEN_W-1:0]   rem_q,   rem_d;
  logic [NUM_W-1:0]   quo_q,   quo_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [QUO_W-1:0]   recip_q, recip_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [STEP_W-1:0]  first_step, run_step;
  logic [DEN_W-1:0]   first_rem,  run_rem;
  logic [NUM_W-1:0]   first_quo,  run_quo;
  logic [QUO_W-1:0]   result;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // den = 0 always fits, so every quotient bit comes out 1.
  function automatic logic [STEP_W-1:0] div_step(
    input logic [DEN_W-1:0] rem,
    input logic [NUM_W-2:0] quo,
    input logic [DEN_W-1:0] den,
    input logic             nbit
  );
    logic [DEN_W:0] ext;
    logic           qbit;
    ext  = {rem, nbit};
    qbit = 1'b0;
    if (ext >= {1'b0, den}) begin
      ext  = ext - {1'b0, den};
      qbit = 1'b1;
    end
    return {ext[DEN_W-1:0], quo, qbit};
  endfunction

  // Step for bit NUM_W-1 from a cleared remainder/quotient with the fresh denom.
  assign first_step = div_step('0, '0, bus.denom, NUMER_V[NUM_W-1]);
  // Step for the bit selected by the counter while running.
  assign run_step   = div_step(rem_q, quo_q[NUM_W-2:0], den_q, NUMER_V[cnt_q]);

  assign {first_rem, first_quo} = first_step;
  assign {run_rem,   run_quo}   = run_step;

`ifdef PERSP_RECIP_ROUND_EN
  logic [DEN_W+1:0] rem_x2;
  logic [NUM_W:0]   quo_rnd;

  // Round half up; the carry into bit NUM_W only matters for saturation.
  assign rem_x2  = {1'b0, run_rem, 1'b0};
  assign quo_rnd = {1'b0, run_quo} + (NUM_W+1)'(rem_x2 >= (DEN_W+2)'(den_q));
  assign result  = (|quo_rnd[NUM_W:QUO_W]) ? '1 : quo_rnd[QUO_W-1:0];
`else
  assign result  = (|run_quo[NUM_W-1:QUO_W]) ? '1 : run_quo[QUO_W-1:0];
`endif

  // State and datapath registers.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      recip_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      recip_q <= recip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: run steps, commit on the last one; a start always (re)begins,
  // which also covers abort-in-RUN and back-to-back on the completion edge.
  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    recip_d = recip_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
      end
      RUN: begin
        rem_d = run_rem;
        quo_d = run_quo;
        if (cnt_q == '0) begin
          recip_d = result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.start) begin
      den_d   = bus.denom;
      rem_d   = first_rem;
      quo_d   = first_quo;
      cnt_d   = CNT_W'(NUM_W - 2);
      busy_d  = 1'b1;
      state_d = RUN;
    end
  end

  assign bus.recip = recip_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_persp_recip_div.sv
// Scoreboard bench for persp_recip_div: the driver pushes the expected
// result and completion cycle per request; a negedge monitor pops on done.
module tb_persp_recip_div;

  localparam int unsigned NUMER = 65535;
  localparam int unsigned DEN_W = 10;
  localparam int unsigned QUO_W = 11;
  localparam int unsigned SAT   = (1 << QUO_W) - 1;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;

  persp_recip_div_if #(.DEN_W(DEN_W), .QUO_W(QUO_W)) bus ();

  persp_recip_div #(
    .NUMER(NUMER), .NUM_W(16), .DEN_W(DEN_W), .QUO_W(QUO_W)
  ) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    int unsigned recip;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int unsigned held = 0;
  int   busy_lo = 0;
  int   busy_hi = 0;

  always @(posedge clk48) cyc <= cyc + 1;

  // Reference: floor (or round-half-up) of NUMER/d, saturated; d=0 saturates.
  function automatic int unsigned ref_recip(input int unsigned d);
    longint unsigned q;
    if (d == 0) return SAT;
`ifdef PERSP_RECIP_ROUND_EN
    q = (2 * longint'(NUMER) + d) / (2 * d);
`else
    q = longint'(NUMER) / d;
`endif
    return (q > SAT) ? SAT : int'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request; start is sampled on the next edge.
  task automatic issue(input int unsigned d);
    exp_t e;
    @(posedge clk48); #1;
    bus.start = 1'b1;
    bus.denom = DEN_W'(d);
    // A request still in flight before its completion edge is aborted.
    if (sb_q.size() > 0 && cyc < sb_q[$].due - 1)
      void'(sb_q.pop_back());
    e.recip = ref_recip(d);
    e.due   = cyc + 16;
    sb_q.push_back(e);
    if (cyc + 1 > busy_hi) busy_lo = cyc + 1;
    busy_hi = cyc + 16;
    @(posedge clk48); #1;
    bus.start = 1'b0;
    bus.denom = DEN_W'($urandom_range(0, 1023));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 64) begin
      @(posedge clk48);
      n++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk48);
  endtask

  // Monitor: result and latency on done, hold otherwise, busy every cycle.
  always @(negedge clk48) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got recip %0d expected no done (cycle %0d)",
                   bus.recip, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("recip", int'(bus.recip), int'(e.recip));
          chk("latency", cyc, e.due);
          held = e.recip;
        end
      end else begin
        chk("recip_hold", int'(bus.recip), int'(held));
      end
      chk("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc < busy_hi));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.denom = '0;
    #1;
    chk("rst_recip", int'(bus.recip), 0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_done",  int'(bus.done),  0);
    repeat (3) @(posedge clk48);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk48);

    // Directed values, including saturation and divide-by-zero.
    issue(34);  drain();
    issue(273); drain();
    issue(1);   drain();
    issue(0);   drain();
    issue(200); drain();
    issue(3);   drain();

    // Abort: second start on E5.
    issue(100);
    repeat (3) @(posedge clk48);
    issue(50);
    drain();

    // Back-to-back: second start on the completion edge.
    issue(34);
    repeat (13) @(posedge clk48);
    issue(273);
    drain();

    // Random requests with random spacing (aborts, back-to-back, idle gaps).
    for (int i = 0; i < 40; i++) begin
      int unsigned d;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 1023);
      issue(d);
      repeat ($urandom_range(0, 20)) @(posedge clk48);
    end
    drain();

    // Asynchronous reset at E7 clears outputs within the cycle.
    issue(500);
    repeat (6) @(posedge clk48);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_recip", int'(bus.recip), 0);
    chk("arst_busy",  int'(bus.busy),  0);
    chk("arst_done",  int'(bus.done),  0);
    sb_q.delete();
    held    = 0;
    busy_lo = 0;
    busy_hi = 0;
    repeat (3) @(posedge clk48);
    #1 rst_n = 1'b1;
    issue(273);
    drain();
    repeat (5) @(posedge clk48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
